fod_mmd_div: RTL

- Programmable multi-modulus divider stage directly downstream of the FOD control-word generator.
- Divides the fast PLL clock (CLK) by the per-period MMD ratio and produces DIV_OUT, the divided clock that clocks the FOD control logic.
- Captures the retimer-select and DTC words once per output period and presents them, period-aligned, to the retimer and DTC.

---
 rtl/fod_mmd_pkg.sv | 20 ++
 rtl/fod_mmd_div_if.sv | 26 ++
 rtl/fod_mmd_cnt.sv | 60 ++++++
 rtl/fod_mmd_div.sv | 85 ++++++++
 4 files changed

// File: rtl/fod_mmd_pkg.sv
// Shared constants and types for the FOD multi-modulus divider.
package fod_mmd_pkg;

    localparam int unsigned WMMD    = 6;
    localparam int unsigned MIN_DIV = 4;
    localparam int unsigned WDTC    = 10;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} mmd_state_t;

    typedef logic [WMMD-1:0] mmd_ratio_t;
    typedef logic [WDTC-1:0] dtc_code_t;

    localparam mmd_ratio_t MIN_RATIO = mmd_ratio_t'(MIN_DIV);

    // Requests below the smallest legal ratio run at that ratio instead.
    function automatic mmd_ratio_t clamp_ratio(input mmd_ratio_t ratio);
        return (ratio < MIN_RATIO) ? MIN_RATIO : ratio;
    endfunction

endpackage

// File: rtl/fod_mmd_div_if.sv
// Control-word inputs and period-aligned outputs of the divider.
interface fod_mmd_div_if;
    import fod_mmd_pkg::*;

    logic       EN;
    mmd_ratio_t MMD_DCW;
    logic       RT_DCW;
    dtc_code_t  DTC_DCW;
    logic       DIV_OUT;
    logic       DCW_LOAD;
    logic       RT_SEL;
    dtc_code_t  DTC_CODE;
    mmd_ratio_t CUR_DIV;
    logic       RATIO_ERR;

    modport master (
        output EN, MMD_DCW, RT_DCW, DTC_DCW,
        input  DIV_OUT, DCW_LOAD, RT_SEL, DTC_CODE, CUR_DIV, RATIO_ERR
    );

    modport slave (
        input  EN, MMD_DCW, RT_DCW, DTC_DCW,
        output DIV_OUT, DCW_LOAD, RT_SEL, DTC_CODE, CUR_DIV, RATIO_ERR
    );

endinterface

// File: rtl/fod_mmd_cnt.sv
// Period down-counter: clamps the requested ratio, detects the terminal cycle
// and produces the registered divided clock.
module fod_mmd_cnt
    import fod_mmd_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_load,
    input  mmd_ratio_t i_ratio,
    output mmd_ratio_t o_cnt,
    output logic       o_tc,
    output logic       o_div_out,
    output mmd_ratio_t o_cur_div,
    output logic       o_clamped
);

    mmd_ratio_t r_cnt;
    mmd_ratio_t r_cur_div;
    logic       r_div_out;
    mmd_ratio_t w_n;
    mmd_ratio_t w_cnt_d;
    mmd_ratio_t w_cur_div_d;
    logic       w_div_out_d;

    assign w_n       = clamp_ratio(i_ratio);
    assign o_clamped = (i_ratio < MIN_RATIO);
    assign o_tc      = (r_cnt == '0);

    // Next count/ratio; without a load the counter parks at zero, which keeps DIV_OUT low in idle.
    always_comb begin
        w_cnt_d     = r_cnt;
        w_cur_div_d = r_cur_div;
        if (i_load) begin
            w_cur_div_d = w_n;
            w_cnt_d     = w_n - mmd_ratio_t'(1);
        end else if (!o_tc) begin
            w_cnt_d = r_cnt - mmd_ratio_t'(1);
        end
        // Compare on next-state values so the registered output lines up with cnt.
        w_div_out_d = (w_cnt_d >= (w_cur_div_d >> 1));
    end

    // Counter, ratio in force and divided clock registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt     <= '0;
            r_cur_div <= MIN_RATIO;
            r_div_out <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_d;
            r_cur_div <= w_cur_div_d;
            r_div_out <= w_div_out_d;
        end
    end

    assign o_cnt     = r_cnt;
    assign o_div_out = r_div_out;
    assign o_cur_div = r_cur_div;

endmodule

// File: rtl/fod_mmd_div.sv
// Multi-modulus divider top: enable FSM, per-period control-word capture and
// sticky ratio error flag around the period counter.
module fod_mmd_div
    import fod_mmd_pkg::*;
(
    input  logic          CLK,
    input  logic          ARST,
    fod_mmd_div_if.slave  bus
);

    mmd_state_t r_state;
    logic       r_dcw_load;
    logic       r_rt_sel;
    dtc_code_t  r_dtc_code;
    logic       r_ratio_err;
    mmd_ratio_t w_cnt;
    logic       w_tc;
    logic       w_div_out;
    mmd_ratio_t w_cur_div;
    logic       w_clamped;
    logic       w_load;

    // A load edge starts a period: from idle, or at the terminal cycle while still enabled.
    assign w_load = bus.EN && ((r_state == IDLE) || w_tc);

    fod_mmd_cnt u_cnt (
        .i_clk     (CLK),
        .i_rst     (ARST),
        .i_load    (w_load),
        .i_ratio   (bus.MMD_DCW),
        .o_cnt     (w_cnt),
        .o_tc      (w_tc),
        .o_div_out (w_div_out),
        .o_cur_div (w_cur_div),
        .o_clamped (w_clamped)
    );

    // FSM with registered load strobe, control-word capture and sticky error.
    always_ff @(posedge CLK or posedge ARST) begin
        if (ARST) begin
            r_state     <= IDLE;
            r_dcw_load  <= 1'b0;
            r_rt_sel    <= 1'b0;
            r_dtc_code  <= '0;
            r_ratio_err <= 1'b0;
        end else begin
            r_dcw_load <= w_load;
            if (w_load) begin
                r_rt_sel   <= bus.RT_DCW;
                r_dtc_code <= bus.DTC_DCW;
                if (w_clamped) begin
                    r_ratio_err <= 1'b1;
                end
            end
            unique case (r_state)
                IDLE: begin
                    if (bus.EN) begin
                        r_state <= RUN;
                    end
                end
                // The current period always completes; EN only decides what follows it.
                RUN, DRAIN: begin
                    if (w_tc) begin
                        r_state <= bus.EN ? RUN : IDLE;
                    end else begin
                        r_state <= bus.EN ? RUN : DRAIN;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Idle always parks the counter at zero, so the first load from idle needs no special case.
    a_idle_cnt_zero: assert property (@(posedge CLK) disable iff (ARST)
        (r_state == IDLE) |-> (w_cnt == '0));

    assign bus.DIV_OUT   = w_div_out;
    assign bus.DCW_LOAD  = r_dcw_load;
    assign bus.RT_SEL    = r_rt_sel;
    assign bus.DTC_CODE  = r_dtc_code;
    assign bus.CUR_DIV   = w_cur_div;
    assign bus.RATIO_ERR = r_ratio_err;

endmodule
